// File: rtl/mixer_pkg.sv
// Shared types and helpers for the sprite layer mixer.
// Life states, colour extraction from the flat layer bus.
package mixer_pkg;

   typedef enum logic [1:0] {
      ALIVE = 2'd0,
      DYING = 2'd1,
      DEAD  = 2'd2
   } life_state_t;

   localparam int COLRW_DEF  = 12;
   localparam int CHANW      = COLRW_DEF / 3;
   localparam int MAX_LAYERS = 16;
   localparam int MAX_COLRW  = 48;
   // One spare colour slot so the widest slice never runs off the end.
   localparam int BUSW = (MAX_LAYERS + 1) * MAX_COLRW;

   function automatic int chan_w(input int colrw);
      return colrw / 3;
   endfunction

   function automatic logic [MAX_COLRW-1:0] get_layer_colr(
      input logic [BUSW-1:0] bus,
      input int              idx,
      input int              colrw
   );
      return bus[idx*colrw +: MAX_COLRW];
   endfunction

endpackage

// File: rtl/layer_prio_sel.sv
// Priority encoder and colour mux across sprite layers.
// Lowest-index visible layer wins, background otherwise.
module layer_prio_sel
   import mixer_pkg::*;
#(
   parameter int LAYERS = 8,
   parameter int COLRW  = 12
) (
   input  logic [LAYERS-1:0]       v_i,
   input  logic [LAYERS*COLRW-1:0] colr_i,
   input  logic [COLRW-1:0]        bg_i,
   output logic [COLRW-1:0]        colr_o
);

   logic [BUSW-1:0] bus;

   assign bus = BUSW'(colr_i);

   // Walk from lowest priority up so layer 0 overrides last.
   always_comb begin
      colr_o = bg_i;
      for (int i = LAYERS - 1; i >= 0; i--) begin
         if (v_i[i]) begin
            colr_o = COLRW'(get_layer_colr(bus, i, COLRW));
         end
      end
   end

endmodule

// File: rtl/sprite_layer_mixer.sv
// N-layer sprite compositor with player collision tracking.
// Two-stage pixel pipeline plus ALIVE/DYING/DEAD life FSM.
module sprite_layer_mixer
   import mixer_pkg::*;
#(
   parameter int LAYERS       = 8,
   parameter int COLRW        = 12,
   parameter int PLAYER       = 0,
   parameter int DEATH_FRAMES = 60,
   parameter int HITW         = 8
) (
   input  logic                    clk_pix,
   input  logic                    rst_pix_n,
   input  logic                    de,
   input  logic                    frame,
   input  logic [LAYERS-1:0]       layer_en,
   input  logic [LAYERS-1:0]       layer_drawing,
   input  logic [LAYERS*COLRW-1:0] layer_colr,
   input  logic [COLRW-1:0]        bg_colr,
   input  logic                    restart,
   output logic [COLRW-1:0]        pix_colr,
   output logic                    pix_de,
   output logic [LAYERS-1:0]       coll_live,
   output logic [LAYERS-1:0]       coll_frame,
   output logic                    hit,
   output logic [HITW-1:0]         hit_cnt,
   output logic [1:0]              state
);

   localparam int CNTW = $clog2(DEATH_FRAMES + 1);

   logic [LAYERS-1:0]       v_q;
   logic [LAYERS*COLRW-1:0] colr_q;
   logic [COLRW-1:0]        bg_q;
   logic                    de_q;

   logic [COLRW-1:0]        sel_colr;
   logic [LAYERS-1:0]       coll_d;

   logic [COLRW-1:0]        pix_colr_q;
   logic                    pix_de_q;
   logic [LAYERS-1:0]       coll_live_q;
   logic [LAYERS-1:0]       acc_q;
   logic [LAYERS-1:0]       coll_frame_q;

   life_state_t             state_q, state_d;
   logic [CNTW-1:0]         cnt_q, cnt_d;
   logic                    hit_q, hit_d;
   logic [HITW-1:0]         hit_cnt_q, hit_cnt_d;

   // Stage 1: mask drawing flags and register colours alongside.
   always_ff @(posedge clk_pix or negedge rst_pix_n) begin
      if (!rst_pix_n) begin
         v_q    <= '0;
         colr_q <= '0;
         bg_q   <= '0;
         de_q   <= 1'b0;
      end else begin
         v_q    <= layer_drawing & layer_en;
         colr_q <= layer_colr;
         bg_q   <= bg_colr;
         de_q   <= de;
      end
   end

   layer_prio_sel #(
      .LAYERS (LAYERS),
      .COLRW  (COLRW)
   ) u_sel (
      .v_i    (v_q),
      .colr_i (colr_q),
      .bg_i   (bg_q),
      .colr_o (sel_colr)
   );

   // Overlap with the player; the player never collides with itself.
   always_comb begin
      coll_d         = v_q & {LAYERS{v_q[PLAYER] & de_q}};
      coll_d[PLAYER] = 1'b0;
   end

   // Stage 2: painted pixel and live collision mask.
   always_ff @(posedge clk_pix or negedge rst_pix_n) begin
      if (!rst_pix_n) begin
         pix_colr_q  <= '0;
         pix_de_q    <= 1'b0;
         coll_live_q <= '0;
      end else begin
         pix_colr_q  <= de_q ? sel_colr : '0;
         pix_de_q    <= de_q;
         coll_live_q <= coll_d;
      end
   end

   // Per-frame collision accumulation; the frame cycle closes the frame.
   always_ff @(posedge clk_pix or negedge rst_pix_n) begin
      if (!rst_pix_n) begin
         acc_q        <= '0;
         coll_frame_q <= '0;
      end else if (frame) begin
         acc_q        <= '0;
         coll_frame_q <= acc_q | coll_live_q;
      end else begin
         acc_q        <= acc_q | coll_live_q;
      end
   end

   // Life FSM state register.
   always_ff @(posedge clk_pix or negedge rst_pix_n) begin
      if (!rst_pix_n) begin
         state_q   <= ALIVE;
         cnt_q     <= '0;
         hit_q     <= 1'b0;
         hit_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         hit_q     <= hit_d;
         hit_cnt_q <= hit_cnt_d;
      end
   end

   // Life FSM next state; restart overrides everything.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      hit_d     = 1'b0;
      hit_cnt_d = hit_cnt_q;
      if (restart) begin
         state_d = ALIVE;
         cnt_d   = '0;
      end else begin
         unique case (state_q)
            ALIVE: begin
               if (|coll_live_q) begin
                  state_d = DYING;
                  hit_d   = 1'b1;
                  cnt_d   = CNTW'(DEATH_FRAMES);
                  if (hit_cnt_q != '1) begin
                     hit_cnt_d = hit_cnt_q + 1'b1;
                  end
               end
            end
            DYING: begin
               if (frame) begin
                  cnt_d = cnt_q - 1'b1;
                  if (cnt_q == CNTW'(1)) begin
                     state_d = DEAD;
                  end
               end
            end
            DEAD: begin
               state_d = DEAD;
            end
            default: begin
               state_d = ALIVE;
            end
         endcase
      end
   end

   assign pix_colr   = pix_colr_q;
   assign pix_de     = pix_de_q;
   assign coll_live  = coll_live_q;
   assign coll_frame = coll_frame_q;
   assign hit        = hit_q;
   assign hit_cnt    = hit_cnt_q;
   assign state      = state_q;

endmodule

// File: tb/tb_sprite_layer_mixer.sv
// Randomised and directed bench for sprite_layer_mixer.
// Reference model works on whole input snapshots per cycle.
module tb_sprite_layer_mixer;

   localparam int L   = 8;
   localparam int CW  = 12;
   localparam int DF  = 60;
   localparam int HW  = 2;
   localparam int SAT = (1 << HW) - 1;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            de, frame, restart;
   logic [L-1:0]    en, drw;
   logic [L*CW-1:0] colr;
   logic [CW-1:0]   bg;

   logic [CW-1:0]   pix_colr;
   logic            pix_de;
   logic [L-1:0]    coll_live, coll_frame;
   logic            hit;
   logic [HW-1:0]   hit_cnt;
   logic [1:0]      state;

   int n_chk = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   sprite_layer_mixer #(
      .LAYERS       (L),
      .COLRW        (CW),
      .PLAYER       (0),
      .DEATH_FRAMES (DF),
      .HITW         (HW)
   ) dut (
      .clk_pix       (clk),
      .rst_pix_n     (rst_n),
      .de            (de),
      .frame         (frame),
      .layer_en      (en),
      .layer_drawing (drw),
      .layer_colr    (colr),
      .bg_colr       (bg),
      .restart       (restart),
      .pix_colr      (pix_colr),
      .pix_de        (pix_de),
      .coll_live     (coll_live),
      .coll_frame    (coll_frame),
      .hit           (hit),
      .hit_cnt       (hit_cnt),
      .state         (state)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   typedef struct {
      logic            de;
      logic [L-1:0]    v;
      logic [L*CW-1:0] colr;
      logic [CW-1:0]   bg;
   } rec_t;

   rec_t         prev;
   logic [CW-1:0] m_pix;
   logic          m_pde, m_hit;
   logic [L-1:0]  m_live, m_cf, m_acc;
   int            m_st, m_cnt, m_hits;

   function automatic logic [CW-1:0] paint(input rec_t r);
      if (!r.de) return '0;
      for (int i = 0; i < L; i++)
         if (r.v[i]) return r.colr[i*CW +: CW];
      return r.bg;
   endfunction

   function automatic logic [L-1:0] collide(input rec_t r);
      logic [L-1:0] m;
      m = '0;
      if (r.de && r.v[0])
         for (int i = 1; i < L; i++)
            if (r.v[i]) m[i] = 1'b1;
      return m;
   endfunction

   task automatic model_reset();
      prev   = '{de: 1'b0, v: '0, colr: '0, bg: '0};
      m_pix  = '0;
      m_pde  = 1'b0;
      m_hit  = 1'b0;
      m_live = '0;
      m_cf   = '0;
      m_acc  = '0;
      m_st   = 0;
      m_cnt  = 0;
      m_hits = 0;
   endtask

   task automatic model_edge();
      rec_t         cur;
      logic [L-1:0] old_live;
      old_live = m_live;
      cur.de   = de;
      cur.v    = drw & en;
      cur.colr = colr;
      cur.bg   = bg;
      m_hit    = 1'b0;
      if (restart) begin
         m_st  = 0;
         m_cnt = 0;
      end else if (m_st == 0 && old_live != 0) begin
         m_st  = 1;
         m_hit = 1'b1;
         m_cnt = DF;
         if (m_hits < SAT) m_hits++;
      end else if (m_st == 1 && frame) begin
         m_cnt--;
         if (m_cnt == 0) m_st = 2;
      end
      if (frame) begin
         m_cf  = m_acc | old_live;
         m_acc = '0;
      end else begin
         m_acc = m_acc | old_live;
      end
      m_pix  = paint(prev);
      m_pde  = prev.de;
      m_live = collide(prev);
      prev   = cur;
   endtask

   task automatic step();
      model_edge();
      @(posedge clk);
      #1;
      chk("pix_colr", 32'(pix_colr), 32'(m_pix));
      chk("pix_de", 32'(pix_de), 32'(m_pde));
      chk("coll_live", 32'(coll_live), 32'(m_live));
      chk("coll_frame", 32'(coll_frame), 32'(m_cf));
      chk("hit", 32'(hit), 32'(m_hit));
      chk("hit_cnt", 32'(hit_cnt), 32'(m_hits));
      chk("state", 32'(state), 32'(m_st));
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_pix"}, 32'(pix_colr), 32'd0);
      chk({tag, "_de"}, 32'(pix_de), 32'd0);
      chk({tag, "_live"}, 32'(coll_live), 32'd0);
      chk({tag, "_cf"}, 32'(coll_frame), 32'd0);
      chk({tag, "_hit"}, 32'(hit), 32'd0);
      chk({tag, "_hcnt"}, 32'(hit_cnt), 32'd0);
      chk({tag, "_st"}, 32'(state), 32'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      de = 1'b0; frame = 1'b0; restart = 1'b0;
      en = '0; drw = '0; colr = '0; bg = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk_zero("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // Priority, disable, background, blanking
      for (int i = 0; i < L; i++) colr[i*CW +: CW] = CW'($urandom);
      colr[2*CW +: CW] = 12'h0F0;
      colr[5*CW +: CW] = 12'hF00;
      en = 8'hFF; drw = 8'h24; bg = 12'h00A; de = 1'b1;
      step(); step();
      chk("prio", 32'(pix_colr), 32'h0F0);
      en[2] = 1'b0;
      step(); step();
      chk("dis", 32'(pix_colr), 32'hF00);
      drw = '0;
      step(); step();
      chk("bg", 32'(pix_colr), 32'h00A);
      de = 1'b0; drw = 8'h24;
      step(); step();
      chk("blank", 32'(pix_colr), 32'h0);

      // All layers disabled, then player disabled
      de = 1'b1; en = '0; drw = 8'hFF;
      step(); step();
      chk("en0_bg", 32'(pix_colr), 32'h00A);
      chk("en0_live", 32'(coll_live), 32'h0);
      en = 8'hFE;
      step(); step();
      chk("nop_live", 32'(coll_live), 32'h0);
      chk("nop_pix", 32'(pix_colr), 32'(colr[CW +: CW]));

      // Single collision, death countdown, restart
      en = 8'hFF; drw = 8'h09;
      step();
      drw = '0;
      step();
      chk("live08", 32'(coll_live), 32'h08);
      step();
      chk("hit1", 32'(hit), 32'h1);
      chk("hcnt1", 32'(hit_cnt), 32'h1);
      chk("dying", 32'(state), 32'h1);
      step();
      chk("hit_once", 32'(hit), 32'h0);
      for (int f = 0; f < DF; f++) begin
         frame = 1'b1; step();
         frame = 1'b0; step(); step();
      end
      chk("dead", 32'(state), 32'h2);
      restart = 1'b1; step();
      restart = 1'b0;
      chk("alive", 32'(state), 32'h0);

      // Frame accumulation with a collision on the frame cycle
      frame = 1'b1; step();
      frame = 1'b0;
      drw = 8'h03; step();
      drw = '0; step(); step(); step();
      drw = 8'h11; step();
      drw = '0; step();
      frame = 1'b1; step();
      chk("cf12", 32'(coll_frame), 32'h12);
      frame = 1'b0; step(); step(); step();
      frame = 1'b1; step();
      chk("cf0", 32'(coll_frame), 32'h0);
      frame = 1'b0;
      restart = 1'b1; step();
      restart = 1'b0;

      // Restart coincident with a collision
      drw = 8'h05; step();
      drw = '0; step();
      restart = 1'b1; step();
      chk("sim_hit", 32'(hit), 32'h0);
      chk("sim_st", 32'(state), 32'h0);
      restart = 1'b0; step();
      chk("sim_st2", 32'(state), 32'h0);

      // Hit counter saturation
      for (int k = 0; k < 5; k++) begin
         drw = 8'h81; step();
         drw = '0; step(); step();
         restart = 1'b1; step();
         restart = 1'b0;
      end
      chk("sat", 32'(hit_cnt), 32'(SAT));

      // Random traffic
      for (int n = 0; n < 400; n++) begin
         de      = ($urandom_range(0, 3) != 0);
         frame   = ($urandom_range(0, 7) == 0);
         restart = ($urandom_range(0, 31) == 0);
         en      = L'($urandom);
         drw     = L'($urandom);
         for (int i = 0; i < L; i++) colr[i*CW +: CW] = CW'($urandom);
         bg      = CW'($urandom);
         step();
      end

      // Asynchronous reset while dying
      de = 1'b1; frame = 1'b0; en = 8'hFF;
      restart = 1'b1; drw = '0; step();
      restart = 1'b0; drw = 8'h09; step();
      drw = '0; step(); step();
      chk("pre_rst", 32'(state), 32'h1);
      #3;
      rst_n = 1'b0;
      #1;
      chk_zero("arst");
      model_reset();
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      drw = 8'h04;
      step(); step();
      chk("post_rst", 32'(pix_colr), 32'(colr[2*CW +: CW]));

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
